// File: rtl/arb_defs.sv
// Shared definitions for the round-robin mux arbiter: FSM encodings,
// burst counter width and the round-robin search result type.
package arb_defs;

  localparam int CNT_W = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

endpackage

// File: rtl/MUX_4to1.sv
// Team 4:1 single-bit multiplexer: Y = I[S].
module MUX_4to1 (
  input  logic [3:0] I,
  input  logic [1:0] S,
  output logic       Y
);

  // Select one data bit by the 2-bit select.
  always_comb begin
    Y = 1'b0;
    case (S)
      2'd0:    Y = I[0];
      2'd1:    Y = I[1];
      2'd2:    Y = I[2];
      2'd3:    Y = I[3];
      default: Y = 1'b0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux. One requester holds the
// channel for at most BURST consecutive cycles; grant, select and valid are
// registered, the channel output Y follows I[S] combinationally.
module rr_mux_arbiter
  import arb_defs::*;
#(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] I,
  output logic [3:0] gnt,
  output logic [1:0] S,
  output logic       Y,
  output logic       valid
);

  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       last_r;

  logic [0:0]       state_nxt_s;
  logic [3:0]       gnt_nxt_s;
  logic [1:0]       s_nxt_s;
  logic             valid_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [1:0]       last_nxt_s;

  logic [3:0]       cand_req_s;
  rr_pick_t         pick_s;
  logic             burst_end_s;

  // One-hot decode of a requester index.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // Round-robin search: first set bit at or after (last+1) mod 4, wrapping.
  function automatic rr_pick_t rr_pick(input logic [3:0] req_v,
                                       input logic [1:0] last_v);
    rr_pick_t   res;
    logic [1:0] idx_v;
    res.found = 1'b0;
    res.idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx_v = last_v + 2'(k);
      if (!res.found && req_v[idx_v]) begin
        res.found = 1'b1;
        res.idx   = idx_v;
      end
    end
    return res;
  endfunction

  // Candidates for the next winner: in BUSY the current owner is excluded so
  // a waiting requester always wins over a re-grant.
  always_comb begin
    cand_req_s = req;
    if (state_r == ST_BUSY) begin
      cand_req_s = req & ~onehot(S);
    end else begin
      cand_req_s = req;
    end
  end

  assign pick_s      = rr_pick(cand_req_s, last_r);
  assign burst_end_s = !req[S] || (cnt_r == CNT_W'(BURST - 1));

  // Next-state logic: grant, switch, re-grant or release to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt;
    s_nxt_s     = S;
    valid_nxt_s = valid;
    cnt_nxt_s   = cnt_r;
    last_nxt_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_s.found) begin
          state_nxt_s = ST_BUSY;
          gnt_nxt_s   = onehot(pick_s.idx);
          s_nxt_s     = pick_s.idx;
          valid_nxt_s = 1'b1;
          cnt_nxt_s   = '0;
          last_nxt_s  = pick_s.idx;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!burst_end_s) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else if (pick_s.found) begin
          gnt_nxt_s   = onehot(pick_s.idx);
          s_nxt_s     = pick_s.idx;
          valid_nxt_s = 1'b1;
          cnt_nxt_s   = '0;
          last_nxt_s  = pick_s.idx;
        end else if (req[S]) begin
          // Sole requester at burst end: fresh burst for the same owner.
          cnt_nxt_s   = '0;
          last_nxt_s  = S;
        end else begin
          // Nobody requesting: drop the grant, S keeps its last value.
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = 4'b0000;
          valid_nxt_s = 1'b0;
          cnt_nxt_s   = '0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = 4'b0000;
        valid_nxt_s = 1'b0;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State and registered outputs; reset leaves req[0] with first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      gnt     <= 4'b0000;
      S       <= 2'b00;
      valid   <= 1'b0;
      cnt_r   <= '0;
      last_r  <= 2'd3;
    end else begin
      state_r <= state_nxt_s;
      gnt     <= gnt_nxt_s;
      S       <= s_nxt_s;
      valid   <= valid_nxt_s;
      cnt_r   <= cnt_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  MUX_4to1 u_mux (
    .I (I),
    .S (S),
    .Y (Y)
  );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter (BURST=4): directed steps push the
// hand-computed post-edge outputs; a monitor pops and compares after each edge.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] I;
  logic [3:0] gnt;
  logic [1:0] S;
  logic       Y;
  logic       valid;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic       y;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors;
  int         miscompares;
  logic [3:0] i_pat;

  rr_mux_arbiter #(.BURST(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .I     (I),
    .gnt   (gnt),
    .S     (S),
    .Y     (Y),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected right after the following rising edge.
  task automatic step(input logic rst_v, input logic [3:0] req_v,
                      input logic [3:0] g_v, input logic [1:0] s_v,
                      input logic val_v);
    exp_t e;
    @(negedge clk);
    i_pat = {i_pat[2:0], i_pat[3] ^ i_pat[2]};
    rst   = rst_v;
    req   = req_v;
    I     = i_pat;
    e.gnt   = g_v;
    e.s     = s_v;
    e.valid = val_v;
    e.y     = i_pat[s_v];
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation.
  initial begin
    exp_t e;
    logic bad;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        bad = 1'b0;
        if (gnt !== e.gnt) begin
          $display("FAIL gnt vec%0d: got %b want %b", vectors, gnt, e.gnt);
          bad = 1'b1;
        end
        if (S !== e.s) begin
          $display("FAIL S vec%0d: got %b want %b", vectors, S, e.s);
          bad = 1'b1;
        end
        if (valid !== e.valid) begin
          $display("FAIL valid vec%0d: got %b want %b", vectors, valid, e.valid);
          bad = 1'b1;
        end
        if (Y !== e.y) begin
          $display("FAIL Y vec%0d: got %b want %b", vectors, Y, e.y);
          bad = 1'b1;
        end
        if ($countones(gnt) > 1) begin
          $display("FAIL onehot vec%0d: got %b want at most one bit", vectors, gnt);
          bad = 1'b1;
        end
        if (bad) miscompares++;
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_pat       = 4'b1011;
    rst         = 1'b1;
    req         = 4'b0000;
    I           = 4'b0000;

    // Reset with all requesting, then full contention: 0,1,2,3,0 x4 cycles.
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
    for (int k = 0; k < 17; k++) begin
      step(1'b0, 4'b1111, 4'b0001 << ((k / 4) % 4), 2'((k / 4) % 4), 1'b1);
    end

    // Single requester 2 held 10 cycles: continuous re-grant.
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    end

    // Idle return: S holds 2, then req 0 granted after one cycle.
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1);

    // Early release of owner 1 with req[3] waiting; no pre-emption mid-burst.
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1);
    step(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1);
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1);
    step(1'b0, 4'b1100, 4'b1000, 2'd3, 1'b1);
    step(1'b0, 4'b1100, 4'b1000, 2'd3, 1'b1);
    step(1'b0, 4'b1100, 4'b1000, 2'd3, 1'b1);
    step(1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1);

    // Reset mid-burst (owner 3, counter 2), then a fresh 4-cycle burst.
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1);
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1);
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1);
    step(1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1);
    step(1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1);
    step(1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1);
    step(1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1);
    step(1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
      miscompares++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter BURST, default 4, SHALL set the maximum consecutive cycles one requester holds the shared mux (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 req  input  4  request lines; req[k] high means requester k wants the channel; held until served.
REQ-005 I  input  4  data bits; I[k] belongs to requester k.
REQ-006 gnt  output  4  one-hot grant, registered; all zero when no owner.
REQ-007 S  output  2  registered mux select; equals the encoded owner index.
REQ-008 Y  output  1  shared channel output, I[S], combinational from S and I.
REQ-009 valid  output  1  registered; high exactly when gnt is nonzero.

Function
REQ-010 The FSM SHALL have two states: IDLE (no owner) and BUSY (owner held in S).
REQ-011 IDLE: if req==0, the block SHALL stay in IDLE; otherwise it SHALL select a winner and enter BUSY on the next edge, with gnt, S and valid updated on that edge (1-cycle grant latency).
REQ-012 Winner selection SHALL be round-robin: search starts at index (last+1) mod 4 and ascends with wrap-around; last = most recently granted index.
REQ-013 Only one requester SHALL be granted at a time; gnt SHALL never have more than one bit set.
REQ-014 BUSY: a 4-bit burst counter SHALL be 0 on the first grant cycle and increment each BUSY cycle.
REQ-015 The grant SHALL end after the current cycle when req[S]==0 or counter==BURST-1, whichever comes first.
REQ-016 At grant end, if any req bit other than the owner's is set, the block SHALL switch directly to the next round-robin winner with no idle cycle, reset the counter and update last.
REQ-017 At grant end, if only the owner still requests, the owner SHALL be re-granted for a fresh burst.
REQ-018 At grant end, if req==0 (owner released, nobody else requesting), the block SHALL go to IDLE and clear gnt and valid; S SHALL hold its last value.
REQ-019 Requests rising mid-burst SHALL NOT pre-empt the owner.
REQ-020 Y SHALL equal I[S] in every cycle, independent of valid; consumers qualify with valid.

Reset
REQ-021 On rst high at a clock edge: state=IDLE, gnt=4'b0000, S=2'b00, valid=0, counter=0, last=3 (so req[0] has first priority).
REQ-022 Reset SHALL take priority over all other activity, including mid-burst; the first grant after reset follows REQ-011.

Structure
REQ-023 State encodings (IDLE, BUSY) and the counter width SHALL live in a shared package/include file, `arb_defs`.
REQ-024 The data path SHALL instantiate the team's existing 4:1 mux (MUX_4to1) with S as select and I as data; no second mux implementation.
REQ-025 Round-robin next-winner logic SHALL be a pure combinational function within this module; no further sub-modules.

Verification
REQ-026 Reset: assert rst for 2 cycles with req=4'b1111 -> gnt=0000, valid=0, S=00; first edge after release gives gnt=0001, S=00.
REQ-027 Single requester: req=0100 held 10 cycles, BURST=4 -> gnt=0100 continuously (re-granted every 4 cycles), valid=1, Y tracks I[2].
REQ-028 Full contention: req=1111 held, BURST=4 -> grant order 0,1,2,3,0, each owner exactly 4 cycles, no gap cycles.
REQ-029 Early release: owner 1 drops req after 2 BUSY cycles with req[3] set -> next edge gnt=1000, counter restarts at 0.
REQ-030 Idle return: only owner 2 drops req -> next edge gnt=0000, valid=0, S stays 10; a later req=0001 gives gnt=0001 after 1 cycle.
REQ-031 Reset mid-burst: rst during BUSY with owner 3, counter=2 -> next edge all outputs at reset values; after release, req=1000 is granted with the counter starting at 0.
